// File: rtl/pwl_sequencer.sv
// rtl/pwl_sequencer.sv - PWL command capture buffer and looping batch sequencer for the DAC interpolater
module pwl_sequencer #(
    parameter int SAMPLE_WIDTH   = 16,
    parameter int BATCH_SAMPLES  = 16,
    parameter int DMA_DATA_WIDTH = 48,
    parameter int DEPTH          = 64
) (
    input  logic                      dac_clk,
    input  logic                      dac_rstn,
    input  logic [DMA_DATA_WIDTH-1:0] pwl_tdata,
    input  logic                      pwl_tvalid,
    input  logic                      pwl_tlast,
    output logic                      pwl_tready,
    input  logic                      run,
    input  logic                      halt,
    output logic [SAMPLE_WIDTH-1:0]   x,
    output logic [2*SAMPLE_WIDTH-1:0] slope,
    output logic                      seq_valid,
    output logic [31:0]               pwl_period,
    output logic                      ovf,
    output logic [1:0]                state
);

    localparam int AW = $clog2(DEPTH);
    localparam int BS = $clog2(BATCH_SAMPLES);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2,
        PLAY  = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic                        tready_q;
    logic [AW:0]                 wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]               last_idx_q, last_idx_d;
    logic [AW-1:0]               rd_idx_q, rd_idx_d;
    logic [15:0]                 rem_q, rem_d;
    logic [SAMPLE_WIDTH-1:0]     x_q, x_d;
    logic [2*SAMPLE_WIDTH-1:0]   slope_q, slope_d;
    logic                        valid_q, valid_d;
    logic [31:0]                 period_q, period_d;
    logic                        ovf_q, ovf_d;

    logic [DMA_DATA_WIDTH-1:0]   mem [DEPTH];
    logic                        wr_en;
    logic [AW-1:0]               wr_addr;
    logic                        beat;
    logic [15:0]                 n_in, n_in_eff;
    logic [AW-1:0]               fetch_idx;
    logic [DMA_DATA_WIDTH-1:0]   fetch_word;
    logic [15:0]                 fetch_n_eff;
    logic [SAMPLE_WIDTH-1:0]     x_step;

    assign beat        = pwl_tvalid && tready_q;
    assign n_in        = pwl_tdata[15:0];
    assign n_in_eff    = (n_in == 16'd0) ? 16'd1 : n_in;
    // Entering a command: the first one after run, or the successor (looping) of the current one
    assign fetch_idx   = (!valid_q || rd_idx_q == last_idx_q) ? '0 : rd_idx_q + 1'b1;
    assign fetch_word  = mem[fetch_idx];
    assign fetch_n_eff = (fetch_word[15:0] == 16'd0) ? 16'd1 : fetch_word[15:0];
    assign x_step      = SAMPLE_WIDTH'(slope_q << BS);

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        last_idx_d = last_idx_q;
        rd_idx_d   = rd_idx_q;
        rem_d      = rem_q;
        x_d        = x_q;
        slope_d    = slope_q;
        valid_d    = valid_q;
        period_d   = period_q;
        ovf_d      = ovf_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        case (state_q)
            IDLE, ARMED: begin
                if (beat) begin
                    wr_en      = 1'b1;
                    wr_cnt_d   = (AW+1)'(1);
                    last_idx_d = '0;
                    period_d   = 32'(n_in_eff);
                    ovf_d      = 1'b0;
                    state_d    = pwl_tlast ? ARMED : LOAD;
                end else if (state_q == ARMED && run && !halt) begin
                    state_d = PLAY;
                end
            end
            LOAD: begin
                if (beat) begin
                    if (wr_cnt_q < FULL) begin
                        wr_en      = 1'b1;
                        wr_addr    = wr_cnt_q[AW-1:0];
                        last_idx_d = wr_cnt_q[AW-1:0];
                        wr_cnt_d   = wr_cnt_q + 1'b1;
                        period_d   = period_q + 32'(n_in_eff);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (pwl_tlast) state_d = ARMED;
                end
            end
            PLAY: begin
                if (halt) begin
                    state_d = ARMED;
                    valid_d = 1'b0;
                    x_d     = '0;
                    slope_d = '0;
                end else if (valid_q && rem_q != 16'd0) begin
                    x_d   = x_q + x_step;
                    rem_d = rem_q - 16'd1;
                end else begin
                    valid_d  = 1'b1;
                    rd_idx_d = fetch_idx;
                    x_d      = fetch_word[DMA_DATA_WIDTH-1 -: SAMPLE_WIDTH];
                    slope_d  = (2*SAMPLE_WIDTH)'($signed(fetch_word[31:16]));
                    rem_d    = fetch_n_eff - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dac_clk or negedge dac_rstn) begin
        if (!dac_rstn) begin
            state_q    <= IDLE;
            tready_q   <= 1'b1;
            wr_cnt_q   <= '0;
            last_idx_q <= '0;
            rd_idx_q   <= '0;
            rem_q      <= '0;
            x_q        <= '0;
            slope_q    <= '0;
            valid_q    <= 1'b0;
            period_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tready_q   <= (state_d != PLAY);
            wr_cnt_q   <= wr_cnt_d;
            last_idx_q <= last_idx_d;
            rd_idx_q   <= rd_idx_d;
            rem_q      <= rem_d;
            x_q        <= x_d;
            slope_q    <= slope_d;
            valid_q    <= valid_d;
            period_q   <= period_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge dac_clk) begin
        if (wr_en) mem[wr_addr] <= pwl_tdata;
    end

    assign pwl_tready = tready_q;
    assign x          = x_q;
    assign slope      = slope_q;
    assign seq_valid  = valid_q;
    assign pwl_period = period_q;
    assign ovf        = ovf_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pwl_sequencer.sv
// tb/tb_pwl_sequencer.sv - directed-vector bench for pwl_sequencer
module tb_pwl_sequencer;

    logic        dac_clk = 1'b0;
    logic        dac_rstn;
    logic [47:0] pwl_tdata;
    logic        pwl_tvalid, pwl_tlast, pwl_tready, run, halt;
    logic [15:0] x;
    logic [31:0] slope;
    logic        seq_valid;
    logic [31:0] pwl_period;
    logic        ovf;
    logic [1:0]  state;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] basic_x [5] = '{16'h0100, 16'h0120, 16'h0140, 16'h8000, 16'h0100};
    logic [31:0] basic_s [5] = '{32'h2, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'h2};

    always #5 dac_clk = ~dac_clk;

    pwl_sequencer dut (
        .dac_clk    (dac_clk),
        .dac_rstn   (dac_rstn),
        .pwl_tdata  (pwl_tdata),
        .pwl_tvalid (pwl_tvalid),
        .pwl_tlast  (pwl_tlast),
        .pwl_tready (pwl_tready),
        .run        (run),
        .halt       (halt),
        .x          (x),
        .slope      (slope),
        .seq_valid  (seq_valid),
        .pwl_period (pwl_period),
        .ovf        (ovf),
        .state      (state)
    );

    task automatic cyc();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] x0, input logic [15:0] s, input logic [15:0] n, input logic last);
        pwl_tdata  = {x0, s, n};
        pwl_tvalid = 1'b1;
        pwl_tlast  = last;
        cyc();
        pwl_tvalid = 1'b0;
        pwl_tlast  = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        cyc();
        run = 1'b0;
    endtask

    task automatic pulse_halt();
        halt = 1'b1;
        cyc();
        halt = 1'b0;
    endtask

    task automatic test_reset();
        dac_rstn = 1'b0;
        pwl_tdata = '0; pwl_tvalid = 1'b0; pwl_tlast = 1'b0; run = 1'b0; halt = 1'b0;
        cyc(); cyc();
        vectors++;
        if ({state, pwl_tready, seq_valid, x, slope, pwl_period, ovf} !== {2'd0, 1'b1, 1'b0, 16'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: state=%0d tready=%0b valid=%0b x=%h slope=%h period=%0d ovf=%0b, want 0 1 0 0 0 0 0",
                     state, pwl_tready, seq_valid, x, slope, pwl_period, ovf);
        end
        dac_rstn = 1'b1;
        cyc();
    endtask

    task automatic test_run_in_idle();
        pulse_run();
        cyc();
        vectors++;
        if (state !== 2'd0 || seq_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_in_idle: state=%0d valid=%0b, want 0 0", state, seq_valid);
        end
    endtask

    task automatic test_basic();
        beat(16'h0100, 16'h0002, 16'd3, 1'b0);
        vectors++;
        if (state !== 2'd1) begin errors++; $display("FAIL basic_load_state: got %0d want 1", state); end
        beat(16'h8000, 16'hFFFF, 16'd1, 1'b1);
        vectors++;
        if (pwl_period !== 32'd4 || state !== 2'd2) begin
            errors++;
            $display("FAIL basic_armed: period=%0d state=%0d, want 4 2", pwl_period, state);
        end
        pulse_run();
        vectors++;
        if (state !== 2'd3 || pwl_tready !== 1'b0 || seq_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_run_plus1: state=%0d tready=%0b valid=%0b, want 3 0 0", state, pwl_tready, seq_valid);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            vectors++;
            if (x !== basic_x[k] || slope !== basic_s[k] || seq_valid !== 1'b1) begin
                errors++;
                $display("FAIL basic_batch%0d: x=%h slope=%h valid=%0b, want %h %h 1", k, x, slope, seq_valid, basic_x[k], basic_s[k]);
            end
        end
    endtask

    task automatic test_halt_replay();
        pulse_halt();
        vectors++;
        if (seq_valid !== 1'b0 || state !== 2'd2 || x !== 16'h0 || slope !== 32'h0 || pwl_tready !== 1'b1) begin
            errors++;
            $display("FAIL halt_plus1: valid=%0b state=%0d x=%h slope=%h tready=%0b, want 0 2 0 0 1",
                     seq_valid, state, x, slope, pwl_tready);
        end
        repeat (9) cyc();
        pulse_run();
        for (int k = 0; k < 5; k++) begin
            cyc();
            vectors++;
            if (x !== basic_x[k] || slope !== basic_s[k] || seq_valid !== 1'b1) begin
                errors++;
                $display("FAIL replay_batch%0d: x=%h slope=%h valid=%0b, want %h %h 1", k, x, slope, seq_valid, basic_x[k], basic_s[k]);
            end
        end
    endtask

    task automatic test_halt_run_same();
        halt = 1'b1;
        run  = 1'b1;
        cyc();
        halt = 1'b0;
        run  = 1'b0;
        cyc();
        vectors++;
        if (state !== 2'd2 || seq_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_run_same: state=%0d valid=%0b, want 2 0", state, seq_valid);
        end
    endtask

    task automatic test_load_beats_run();
        pwl_tdata  = {16'h1234, 16'h0000, 16'd5};
        pwl_tvalid = 1'b1;
        run        = 1'b1;
        cyc();
        pwl_tvalid = 1'b0;
        run        = 1'b0;
        vectors++;
        if (state !== 2'd1 || pwl_tready !== 1'b1 || pwl_period !== 32'd5) begin
            errors++;
            $display("FAIL load_beats_run: state=%0d tready=%0b period=%0d, want 1 1 5", state, pwl_tready, pwl_period);
        end
        beat(16'h2000, 16'h0000, 16'd0, 1'b1);
        vectors++;
        if (state !== 2'd2 || pwl_period !== 32'd6) begin
            errors++;
            $display("FAIL reload_armed: state=%0d period=%0d, want 2 6", state, pwl_period);
        end
        pulse_run();
        cyc();
        vectors++;
        if (x !== 16'h1234 || slope !== 32'h0) begin
            errors++;
            $display("FAIL reload_first: x=%h slope=%h, want 1234 0", x, slope);
        end
        pulse_halt();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_period;
        logic [15:0] n;
        exp_period = 32'd0;
        for (int i = 0; i < 67; i++) begin
            n = (i < 64) ? 16'(i % 3) : 16'd100;
            if (i < 64) exp_period += (n == 16'd0) ? 32'd1 : 32'(n);
            vectors++;
            if (pwl_tready !== 1'b1) begin
                errors++;
                $display("FAIL ovf_ready_beat%0d: tready=%0b want 1", i, pwl_tready);
            end
            beat(16'(i * 16), 16'h0000, n, i == 66);
        end
        vectors++;
        if (ovf !== 1'b1 || state !== 2'd2 || pwl_period !== exp_period) begin
            errors++;
            $display("FAIL ovf_final: ovf=%0b state=%0d period=%0d, want 1 2 %0d", ovf, state, pwl_period, exp_period);
        end
        pulse_run();
        for (int k = 0; k < 86; k++) begin
            cyc();
            if (k == 0 || k == 85) begin
                vectors++;
                if (x !== 16'h0000) begin errors++; $display("FAIL ovf_play_batch%0d: x=%h want 0000", k, x); end
            end else if (k == 84) begin
                vectors++;
                if (x !== 16'h03F0) begin errors++; $display("FAIL ovf_play_last: x=%h want 03f0", x); end
            end
        end
        pulse_halt();
    endtask

    task automatic test_n_zero();
        beat(16'h7FF0, 16'h0001, 16'd0, 1'b1);
        vectors++;
        if (ovf !== 1'b0 || pwl_period !== 32'd1 || state !== 2'd2) begin
            errors++;
            $display("FAIL nzero_armed: ovf=%0b period=%0d state=%0d, want 0 1 2", ovf, pwl_period, state);
        end
        pulse_run();
        for (int k = 0; k < 4; k++) begin
            cyc();
            vectors++;
            if (x !== 16'h7FF0 || slope !== 32'h1 || seq_valid !== 1'b1) begin
                errors++;
                $display("FAIL nzero_batch%0d: x=%h slope=%h valid=%0b, want 7ff0 1 1", k, x, slope, seq_valid);
            end
        end
        pulse_halt();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_x [3];
        exp_x = '{16'h7FF0, 16'h8000, 16'h7FF0};
        beat(16'h7FF0, 16'h0001, 16'd2, 1'b1);
        pulse_run();
        for (int k = 0; k < 3; k++) begin
            cyc();
            vectors++;
            if (x !== exp_x[k]) begin
                errors++;
                $display("FAIL wrap_batch%0d: x=%h want %h", k, x, exp_x[k]);
            end
        end
    endtask

    task automatic test_reset_mid_play();
        #2;
        dac_rstn = 1'b0;
        #1;
        vectors++;
        if ({state, pwl_tready, seq_valid, x, slope, pwl_period, ovf} !== {2'd0, 1'b1, 1'b0, 16'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_play: state=%0d tready=%0b valid=%0b x=%h slope=%h period=%0d ovf=%0b, want 0 1 0 0 0 0 0",
                     state, pwl_tready, seq_valid, x, slope, pwl_period, ovf);
        end
        cyc();
        dac_rstn = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_run_in_idle();
        test_basic();
        test_halt_replay();
        test_halt_run_same();
        test_load_beats_run();
        test_overflow();
        test_n_zero();
        test_wrap();
        test_reset_mid_play();
        test_run_in_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
